// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the echo buffer scheduler.
package audio_pkg;
    localparam int AUDIO_ADDR_WIDTH = 12;
    localparam int MIX_WIDTH = 18;
    localparam logic [1:0][AUDIO_ADDR_WIDTH-1:0] DEFAULT_TAP_DELAY = {12'd3000, 12'd1500};
    typedef enum logic [2:0] {IDLE, WRITE, RD_MAIN, RD_TAP, DRAIN, OUT} sched_state_t;
endpackage

// File: rtl/tap_accumulator.sv
// tap_accumulator: running signed sum of arithmetically shifted read data for the echo mix.
module tap_accumulator
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SHIFT_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          add,
    input  logic signed [DATA_WIDTH-1:0]  data,
    input  logic        [SHIFT_WIDTH-1:0] shift,
    output logic signed [MIX_WIDTH-1:0]   sum
);
    logic signed [MIX_WIDTH-1:0] acc;
    logic signed [MIX_WIDTH-1:0] addend;
    // sum already includes the word arriving this cycle so the final tap lands with the output load
    always_comb begin
        addend = MIX_WIDTH'(data) >>> shift;
        sum = add ? acc + addend : acc;
    end
    always_ff @(posedge clk) begin
        if (rst || clear) acc <= '0;
        else acc <= sum;
    end
endmodule

// File: rtl/echo_buffer_scheduler.sv
// echo_buffer_scheduler: time-multiplexes one BRAM port between recording, loop playback
// and echo taps, producing a dry sample and an echo mix once per audio strobe.
module echo_buffer_scheduler
    import audio_pkg::*;
#(
    parameter int ADDR_WIDTH = AUDIO_ADDR_WIDTH,
    parameter int DATA_WIDTH = 16,
    parameter int N_TAPS = 2,
    parameter logic [N_TAPS-1:0][ADDR_WIDTH-1:0] TAP_DELAY = DEFAULT_TAP_DELAY
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic signed [DATA_WIDTH-1:0] audio_in,
    input  logic                         audio_valid_in,
    input  logic                         record_in,
    output logic        [ADDR_WIDTH-1:0] mem_addr_out,
    output logic                         mem_we_out,
    output logic signed [DATA_WIDTH-1:0] mem_din_out,
    input  logic signed [DATA_WIDTH-1:0] mem_dout_in,
    output logic signed [DATA_WIDTH-1:0] main_out,
    output logic signed [MIX_WIDTH-1:0]  mix_out,
    output logic                         sample_valid_out,
    output logic                         busy_out,
    output logic                         overrun_out
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW = N_TAPS > 1 ? $clog2(N_TAPS) : 1;
    localparam int SW = $clog2(N_TAPS + 1);
    typedef logic [ADDR_WIDTH:0] ext_t;

    sched_state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic rec_l, prev_rec;
    logic signed [DATA_WIDTH-1:0] sample_l, main_cap;
    ext_t rec_addr, length, cur, cur_inc, delay;
    logic [ADDR_WIDTH-1:0] play_addr, play_base, tap_addr;
    logic [1:0] sr_v;
    logic [1:0][SW-1:0] sr_s;
    logic issue, tap_ok, strobe, do_write, load, main_hit;
    logic [SW-1:0] issue_shift;
    logic signed [MIX_WIDTH-1:0] mix_sum;

    always_comb begin
        strobe = state == IDLE && audio_valid_in;
        do_write = state == WRITE && rec_l && rec_addr < ext_t'(DEPTH);
        cur = ext_t'(play_addr) >= length ? '0 : ext_t'(play_addr);
        cur_inc = cur + ext_t'(1);
        delay = ext_t'(TAP_DELAY[cnt]);
        tap_ok = delay < length;
        // negative offsets wrap around the current loop length, not the whole buffer
        tap_addr = ADDR_WIDTH'(ext_t'(play_base) >= delay ? ext_t'(play_base) - delay
                                                          : ext_t'(play_base) + length - delay);
        load = state == DRAIN && cnt == CW'(1);
        main_hit = sr_v[1] && sr_s[1] == '0;
        busy_out = state != IDLE;
    end

    always_comb begin
        state_d = state;
        cnt_d = cnt;
        mem_we_out = 1'b0;
        mem_addr_out = '0;
        mem_din_out = '0;
        issue = 1'b0;
        issue_shift = '0;
        case (state)
            IDLE: state_d = audio_valid_in ? WRITE : IDLE;
            WRITE: begin
                mem_we_out = do_write;
                mem_addr_out = do_write ? rec_addr[ADDR_WIDTH-1:0] : '0;
                mem_din_out = do_write ? sample_l : '0;
                state_d = RD_MAIN;
            end
            RD_MAIN: begin
                issue = length != '0;
                mem_addr_out = issue ? cur[ADDR_WIDTH-1:0] : '0;
                cnt_d = '0;
                state_d = RD_TAP;
            end
            RD_TAP: begin
                issue = tap_ok;
                issue_shift = SW'(cnt) + SW'(1);
                mem_addr_out = tap_ok ? tap_addr : '0;
                state_d = cnt == CW'(N_TAPS - 1) ? DRAIN : RD_TAP;
                cnt_d = cnt == CW'(N_TAPS - 1) ? '0 : cnt + CW'(1);
            end
            DRAIN: begin
                state_d = cnt == CW'(1) ? OUT : DRAIN;
                cnt_d = cnt + CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            cnt <= '0;
            rec_l <= 1'b0;
            prev_rec <= 1'b0;
            sample_l <= '0;
            rec_addr <= '0;
            length <= '0;
            play_addr <= '0;
            play_base <= '0;
            sr_v <= '0;
            sr_s <= '0;
            main_cap <= '0;
            main_out <= '0;
            mix_out <= '0;
            sample_valid_out <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            sr_v <= {sr_v[0], issue};
            sr_s <= {sr_s[0], issue_shift};
            sample_valid_out <= load;
            if (audio_valid_in && state != IDLE) overrun_out <= 1'b1;
            if (strobe) begin
                rec_l <= record_in;
                prev_rec <= record_in;
                sample_l <= audio_in;
                main_cap <= '0;
                if (record_in && !prev_rec) rec_addr <= '0;
            end
            if (do_write) begin
                rec_addr <= rec_addr + ext_t'(1);
                length <= rec_addr + ext_t'(1);
            end
            if (state == RD_MAIN && length != '0) begin
                play_base <= cur[ADDR_WIDTH-1:0];
                play_addr <= cur_inc >= length ? '0 : cur_inc[ADDR_WIDTH-1:0];
            end
            if (main_hit) main_cap <= mem_dout_in;
            if (load) begin
                main_out <= main_hit ? mem_dout_in : main_cap;
                mix_out <= mix_sum;
            end
        end
    end

    tap_accumulator #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT_WIDTH(SW)
    ) u_acc (
        .clk  (clk_in),
        .rst  (rst_in),
        .clear(strobe),
        .add  (sr_v[1]),
        .data (mem_dout_in),
        .shift(sr_s[1]),
        .sum  (mix_sum)
    );
endmodule

// File: doc/echo_buffer_scheduler.md
# echo_buffer_scheduler

Sequences the single shared audio-buffer BRAM port among the recorder, the loop-playback reader and N_TAPS echo-tap readers, one full schedule per audio sample strobe. Sits between the audio sample pipeline and the `xilinx_true_dual_port_read_first_2_clock_ram` buffer. It owns all addressing, loop length and wrap-around, and emits a dry sample plus an echo mix each sample period.

## Interface

Parameters:
- `ADDR_WIDTH`, 12: buffer address width; DEPTH = 2**ADDR_WIDTH = 4096 words.
- `DATA_WIDTH`, 16: sample width, signed.
- `N_TAPS`, 2: number of echo taps.
- `TAP_DELAY`, {1500, 3000}: per-tap delay in samples; each value must be less than DEPTH.

Ports:
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset, synchronous, active-high.
- `audio_in` in 16: signed sample to record.
- `audio_valid_in` in 1: one-cycle sample strobe.
- `record_in` in 1: level; record while high.
- `mem_addr_out` out ADDR_WIDTH: BRAM port-A address.
- `mem_we_out` out 1: BRAM port-A write enable.
- `mem_din_out` out 16: BRAM write data.
- `mem_dout_in` in 16: BRAM read data; 2-cycle read latency, read-first.
- `main_out` out 16: signed dry playback sample.
- `mix_out` out 18: signed echo mix.
- `sample_valid_out` out 1: one-cycle pulse when `main_out` and `mix_out` update.
- `busy_out` out 1: high whenever the FSM is not in IDLE.
- `overrun_out` out 1: sticky; set when a strobe arrives while busy.

## Operation

- FSM states:
  - IDLE: leaves on `audio_valid_in`; latches `record_in` and `audio_in`.
  - WRITE: one cycle.
  - RD_MAIN: one cycle.
  - RD_TAP: N_TAPS cycles, counted by a tap counter.
  - DRAIN: two cycles.
  - OUT: one cycle, then back to IDLE.
- WRITE:
  - If the latched record bit is 1: `mem_we_out`=1, `mem_addr_out`=rec_addr, `mem_din_out`=latched sample.
  - Then rec_addr += 1 and length = rec_addr+1, with length saturating at DEPTH; rec_addr does not wrap.
  - If the latched record bit is 0: no write.
- Record restart: a strobe with record=1 when the previous strobe had record=0 writes at address 0 and sets length=1.
- RD_MAIN: issue the read at play_addr. Then play_addr += 1, and play_addr becomes 0 if the new value is >= length.
- RD_TAP i: tap address = play_addr − TAP_DELAY[i], using the play_addr value before the increment.
  - If the result is negative, add length.
  - If TAP_DELAY[i] >= length, the tap is invalid: no read is needed and its contribution is 0.
- `mem_we_out` is 0 in every state other than WRITE.
- Read capture: a 2-deep valid/tag shift register tracks issued reads. Data is captured when the tag emerges, two cycles after issue.
- Mix: mix = main + Σ (tap_i >>> (i+1)), computed arithmetically sign-extended to 18 bits. No saturation is needed; the worst-case magnitude is below 2^17.
- length = 0 (nothing recorded yet): no reads are issued; `main_out`=0 and `mix_out`=0, but `sample_valid_out` still pulses.
- Playing and recording at once: playback loops over the growing length.
- Strobe while busy: the strobe is dropped, `overrun_out` is set to 1, and the schedule in progress is unaffected.

## Timing

- Strobe sampled in cycle 0:
  - WRITE in cycle 1.
  - RD_MAIN in cycle 2.
  - Taps in cycles 3..2+N_TAPS.
  - Last tap data valid in cycle 4+N_TAPS.
  - `sample_valid_out` high in cycle 5+N_TAPS, i.e. cycle 7 for N_TAPS=2.
- `main_out` and `mix_out` are registered and hold their values between pulses.
- Minimum strobe spacing: 6+N_TAPS cycles.
- Reset values: state IDLE, rec_addr/play_addr/length 0. All outputs are 0, including `mem_*`, `main_out`, `mix_out`, `sample_valid_out`, `busy_out` and `overrun_out`.
- Reset mid-schedule: returns to IDLE the next cycle, discards in-flight reads and emits no valid pulse.

## Structure

- Shared package `audio_pkg` holds:
  - the `sched_state_t` enum: IDLE, WRITE, RD_MAIN, RD_TAP, DRAIN, OUT;
  - `AUDIO_ADDR_WIDTH`;
  - the default `TAP_DELAY` array;
  - `MIX_WIDTH`=18.
- One sub-module, `tap_accumulator`: clear / add-shifted / result, signed 18-bit. It takes the captured data, tap index and valid flag.
- The BRAM is instantiated by the parent, not inside this block.

## Test plan

- **Reset:** assert `rst_in` mid-schedule at cycle 3 → no `sample_valid_out`, all outputs 0, `busy_out`=0 next cycle.
- **Record ramp:** record 5 samples of values 10..14, then strobe with record=0 → writes to addresses 0..4, length=5. Playback `main_out` sequence is 10, 11, 12, 13, 14, 10 (wraps). Each pulse arrives 7 cycles after its strobe.
- **Echo mix:** record a 3500-sample impulse (1000 at address 0, else 0), then play. At play_addr=1500, `mix_out`=500. At play_addr=3000, `mix_out`=250. At play_addr=0, `mix_out`=1000 and `main_out`=1000.
- **Invalid tap:** length=2000 → tap1 (delay 3000) contributes 0. Tap0 wraps: at play_addr=100 it reads address 600.
- **Overrun:** strobes 4 cycles apart → the second is dropped, `overrun_out`=1 and stays 1; only one valid pulse.
- **Empty / restart:** strobe with length=0 → valid pulse with `main_out`=0 and `mix_out`=0. Record 0→1 after a prior recording → write at address 0, length=1.
